// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: default widths and load funct3 encodings.
package wb_stage_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_RFIDX_WIDTH = 5;
    localparam int INSTRET_WIDTH  = 64;

    localparam logic [2:0] LB_F3  = 3'b000;
    localparam logic [2:0] LH_F3  = 3'b001;
    localparam logic [2:0] LW_F3  = 3'b010;
    localparam logic [2:0] LBU_F3 = 3'b100;
    localparam logic [2:0] LHU_F3 = 3'b101;

    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 == LB_F3) || (f3 == LH_F3) || (f3 == LW_F3) ||
               (f3 == LBU_F3) || (f3 == LHU_F3);
    endfunction

endpackage

// File: rtl/wb_load_fmt.sv
// Load data formatter: byte/halfword extraction with sign or zero extension.
module wb_load_fmt
    import wb_stage_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    input  logic            is_load_i,
    output logic [XLEN-1:0] data_fmt_o,
    output logic            illegal_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = data_i[8*addr_lo_i +: 8];
    assign ld_half = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        data_fmt_o = data_i;
        illegal_o  = is_load_i & ~f3_is_legal(funct3_i);
        if (is_load_i) begin
            case (funct3_i)
                LB_F3:   data_fmt_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
                LBU_F3:  data_fmt_o = {{(XLEN-8){1'b0}}, ld_byte};
                LH_F3:   data_fmt_o = {{(XLEN-16){ld_half[15]}}, ld_half};
                LHU_F3:  data_fmt_o = {{(XLEN-16){1'b0}}, ld_half};
                default: data_fmt_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: formats retiring results, buffers them in order, drives the
// regfile write port one entry per cycle and forwards buffered results to decode.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN        = DEF_XLEN,
    parameter int RFIDX_WIDTH = DEF_RFIDX_WIDTH,
    parameter int DEPTH       = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RFIDX_WIDTH-1:0]   in_rd,
    input  logic                     in_wen,
    input  logic                     in_is_load,
    input  logic [2:0]               in_funct3,
    input  logic [1:0]               in_addr_lo,
    input  logic [XLEN-1:0]          in_data,
    output logic                     reg_write,
    output logic [RFIDX_WIDTH-1:0]   write_addr,
    output logic [XLEN-1:0]          write_data,
    input  logic [RFIDX_WIDTH-1:0]   fwd_addr1,
    input  logic [RFIDX_WIDTH-1:0]   fwd_addr2,
    output logic                     fwd_valid1,
    output logic                     fwd_valid2,
    output logic [XLEN-1:0]          fwd_data1,
    output logic [XLEN-1:0]          fwd_data2,
    output logic                     fmt_err,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic                     empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [RFIDX_WIDTH-1:0]   rd_q   [DEPTH];
    logic                     wen_q  [DEPTH];
    logic [XLEN-1:0]          data_q [DEPTH];
    logic [PW-1:0]            rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]            count_q, count_d;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic                     fmt_err_q;

    logic [XLEN-1:0] data_fmt;
    logic            illegal;
    logic            push, pop;

    wb_load_fmt #(.XLEN(XLEN)) u_fmt (
        .data_i     (in_data),
        .addr_lo_i  (in_addr_lo),
        .funct3_i   (in_funct3),
        .is_load_i  (in_is_load),
        .data_fmt_o (data_fmt),
        .illegal_o  (illegal)
    );

    // Ready depends only on occupancy, so a full buffer takes a bubble even when popping.
    assign in_ready = (count_q < CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = in_valid & in_ready;
    assign pop      = ~empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            instret_q <= '0;
            fmt_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            fmt_err_q <= push & illegal;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                instret_q <= instret_q + INSTRET_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            rd_q[wr_ptr_q]   <= in_rd;
            wen_q[wr_ptr_q]  <= in_wen;
            data_q[wr_ptr_q] <= data_fmt;
        end
    end

    // A reset edge must not also commit the head entry to the regfile.
    assign write_addr = rd_q[rd_ptr_q];
    assign write_data = data_q[rd_ptr_q];
    assign reg_write  = rst_n & ~empty & wen_q[rd_ptr_q] & (rd_q[rd_ptr_q] != '0);
    assign fmt_err    = fmt_err_q;
    assign instret    = instret_q;

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        fwd_valid1 = 1'b0;
        fwd_valid2 = 1'b0;
        fwd_data1  = '0;
        fwd_data2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && wen_q[idx] && (rd_q[idx] != '0)) begin
                if (rd_q[idx] == fwd_addr1) begin
                    fwd_valid1 = 1'b1;
                    fwd_data1  = data_q[idx];
                end
                if (rd_q[idx] == fwd_addr2) begin
                    fwd_valid2 = 1'b1;
                    fwd_data2  = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases plus random traffic against a queue-based reference.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_wen, in_is_load;
    logic [RW-1:0]   in_rd;
    logic [2:0]      in_funct3;
    logic [1:0]      in_addr_lo;
    logic [XLEN-1:0] in_data;
    logic            reg_write;
    logic [RW-1:0]   write_addr;
    logic [XLEN-1:0] write_data;
    logic [RW-1:0]   fwd_addr1, fwd_addr2;
    logic            fwd_valid1, fwd_valid2;
    logic [XLEN-1:0] fwd_data1, fwd_data2;
    logic            fmt_err;
    logic [63:0]     instret;
    logic            empty;

    wb_stage #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_data(in_data),
        .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .fmt_err(fmt_err), .instret(instret), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0]   rd;
        logic            wen;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    longint unsigned m_instret = 0;
    bit              m_fmt = 0;
    int              errors = 0;
    int              checks = 0;
    logic [XLEN-1:0] rf [32];

    always @(posedge clk) if (reg_write) rf[write_addr] <= write_data;

    function automatic logic [31:0] ref_fmt(input bit ld, input logic [2:0] f3,
                                            input logic [1:0] alo, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * alo)) & 32'hFF;
        h = (d >> (alo[1] ? 16 : 0)) & 32'hFFFF;
        if (!ld) return d;
        case (f3)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    function automatic bit ref_bad(input bit ld, input logic [2:0] f3);
        return ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit   do_push;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_instret = 0;
            m_fmt = 0;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            m_fmt = do_push && ref_bad(in_is_load, in_funct3);
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                m_instret++;
            end
            if (do_push) begin
                e.rd = in_rd;
                e.wen = in_wen;
                e.data = ref_fmt(in_is_load, in_funct3, in_addr_lo, in_data);
                mq.push_back(e);
            end
        end
    endtask

    task automatic fwd_ref(input logic [RW-1:0] a, output bit v, output logic [31:0] d);
        v = 0;
        d = '0;
        if (a == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!v && mq[i].wen && mq[i].rd == a) begin
                v = 1;
                d = mq[i].data;
            end
        end
    endtask

    task automatic check_model();
        bit          rw, v1, v2;
        logic [31:0] d1, d2;
        rw = (mq.size() > 0) && mq[0].wen && (mq[0].rd != 0) && rst_n;
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        chk("reg_write", 64'(reg_write), 64'(rw));
        if (rw) begin
            chk("write_addr", 64'(write_addr), 64'(mq[0].rd));
            chk("write_data", 64'(write_data), 64'(mq[0].data));
        end
        fwd_ref(fwd_addr1, v1, d1);
        fwd_ref(fwd_addr2, v2, d2);
        chk("fwd_valid1", 64'(fwd_valid1), 64'(v1));
        chk("fwd_valid2", 64'(fwd_valid2), 64'(v2));
        if (v1) chk("fwd_data1", 64'(fwd_data1), 64'(d1));
        if (v2) chk("fwd_data2", 64'(fwd_data2), 64'(d2));
        chk("fmt_err", 64'(fmt_err), 64'(m_fmt));
        chk("instret", instret, m_instret);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input bit v, input logic [RW-1:0] rd, input bit wen, input bit ld,
                         input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] d);
        in_valid = v;
        in_rd = rd;
        in_wen = wen;
        in_is_load = ld;
        in_funct3 = f3;
        in_addr_lo = alo;
        in_data = d;
    endtask

    task automatic idle();
        drive(0, RW'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom);
    endtask

    task automatic ld_case(input string tag, input logic [2:0] f3, input logic [1:0] alo,
                           input logic [31:0] exp);
        drive(1, 9, 1, 1, f3, alo, 32'h80F0_7F01);
        cycle();
        chk(tag, 64'(write_data), 64'(exp));
        idle();
        cycle();
    endtask

    initial begin
        longint unsigned base;
        rst_n = 0;
        fwd_addr1 = 0;
        fwd_addr2 = 0;
        drive(1, 4, 1, 0, 0, 0, 32'hDEAD_BEEF);
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_reg_write", 64'(reg_write), 64'd0);
        chk("rst_instret", instret, 64'd0);
        rst_n = 1;
        idle();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        drive(1, 5, 1, 0, 0, 0, 32'h1234_5678);
        cycle();
        chk("alu_addr", 64'(write_addr), 64'd5);
        chk("alu_data", 64'(write_data), 64'h1234_5678);
        chk("alu_rw", 64'(reg_write), 64'd1);
        idle();
        cycle();
        chk("alu_rf_x5", 64'(rf[5]), 64'h1234_5678);
        chk("alu_instret", instret, 64'd1);

        ld_case("lb_a2", LB_F3, 2'd2, 32'hFFFF_FFF0);
        ld_case("lbu_a3", LBU_F3, 2'd3, 32'h0000_0080);
        ld_case("lh_a2", LH_F3, 2'd2, 32'hFFFF_80F0);
        ld_case("lhu_a0", LHU_F3, 2'd0, 32'h0000_7F01);
        drive(1, 9, 1, 1, 3'b011, 2'd1, 32'h80F0_7F01);
        cycle();
        chk("bad_f3_data", 64'(write_data), 64'h80F0_7F01);
        chk("bad_f3_err", 64'(fmt_err), 64'd1);
        idle();
        cycle();
        chk("bad_f3_err_clr", 64'(fmt_err), 64'd0);

        base = m_instret;
        drive(1, 0, 1, 0, 0, 0, 32'hFFFF_FFFF);
        cycle();
        chk("x0_rw", 64'(reg_write), 64'd0);
        drive(1, 7, 0, 0, 0, 0, 32'h7777_7777);
        cycle();
        chk("wen0_rw", 64'(reg_write), 64'd0);
        idle();
        cycle();
        chk("x0_instret", instret, base + 2);

        for (int i = 0; i < 8; i++) begin
            drive(1, RW'(10 + i), 1, 0, 0, 0, 32'h100 + i);
            cycle();
            chk("stream_data", 64'(write_data), 64'h100 + i);
            chk("stream_addr", 64'(write_addr), 64'(10 + i));
        end
        idle();
        cycle();

        fwd_addr1 = 3;
        fwd_addr2 = 0;
        drive(1, 3, 1, 0, 0, 0, 32'hA);
        cycle();
        drive(1, 3, 1, 0, 0, 0, 32'hB);
        cycle();
        chk("fwd1_valid", 64'(fwd_valid1), 64'd1);
        chk("fwd1_data", 64'(fwd_data1), 64'hB);
        chk("fwd2_x0", 64'(fwd_valid2), 64'd0);
        idle();
        cycle();

        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            fwd_addr1 = RW'($urandom_range(0, 7));
            fwd_addr2 = RW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0)
                drive(1, RW'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                      3'($urandom), 2'($urandom), $urandom);
            else
                idle();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
